// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGES chunks of
// CW = WIDTH/STAGES bits, one chunk per pipeline stage, with the chunk carry
// registered between stages. Valid/ready handshake on both sides, flush,
// and registered flags at the output.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous clear of every in-flight operation
//   in_valid/in_ready   input handshake; a, b, sub captured on transfer
//   a, b                WIDTH-bit operands
//   sub                 0: a+b, 1: a-b (a + ~b + 1)
//   out_valid/out_ready output handshake
//   sum                 result modulo 2^WIDTH
//   carry_out           carry out of the MSB (sub: 1 = no borrow)
//   overflow            two's-complement signed overflow
//   zero                sum == 0
module pipelined_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CW = WIDTH / STAGES;
  localparam int unsigned L  = STAGES - 1;

  // Per-stage registers
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] cy;
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic              ov_q;
  logic              z_q;

  // Per-stage load sources and next values
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_r [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;
  logic [CW:0]       chunk [STAGES];
  logic [WIDTH-1:0]  nres  [STAGES];
  logic              nov;
  logic              nz;

  logic [STAGES-1:0] tail_full;
  logic [STAGES-1:0] adv;

  // Stage k advances unless it and every stage after it are full while the
  // consumer stalls. Written as a per-stage reduction over vld[L:k] rather
  // than a chained adv[k] <- adv[k+1] recurrence to keep the net acyclic.
  always_comb begin
    tail_full = '0;
    adv       = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      tail_full[k] = &(vld | STAGES'((32'd1 << k) - 32'd1));
      adv[k]       = !tail_full[k] || out_ready;
    end
  end

  assign in_ready = adv[0];

  // Stage 0 loads from the ports; stage k loads from stage k-1.
  always_comb begin
    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    src_c[0] = sub;
    src_r[0] = '0;
    src_v[0] = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_c[k] = cy[k-1];
      src_r[k] = res_q[k-1];
      src_v[k] = vld[k-1];
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      chunk[k] = {1'b0, src_a[k][k*CW +: CW]} + {1'b0, src_b[k][k*CW +: CW]}
               + {{CW{1'b0}}, src_c[k]};
      nres[k]  = src_r[k];
      nres[k][k*CW +: CW] = chunk[k][CW-1:0];
    end
    // Carry into the MSB recovered from the MSB sum bit and its operands.
    nov = (src_a[L][WIDTH-1] ^ src_b[L][WIDTH-1] ^ chunk[L][CW-1]) ^ chunk[L][CW];
    nz  = (nres[L] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= '0;
      cy   <= '0;
      ov_q <= 1'b0;
      z_q  <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        res_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else if (flush) begin
      vld <= '0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          vld[k] <= src_v[k];
          // Data only moves with a valid operation, so a stalled or empty
          // output keeps its last value.
          if (src_v[k]) begin
            cy[k]    <= chunk[k][CW];
            res_q[k] <= nres[k];
            a_q[k]   <= src_a[k];
            b_q[k]   <= src_b[k];
            if (k == L) begin
              ov_q <= nov;
              z_q  <= nz;
            end
          end
        end
      end
    end
  end

  assign out_valid = vld[L];
  assign sum       = res_q[L];
  assign carry_out = cy[L];
  assign overflow  = ov_q;
  assign zero      = z_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Testbench for pipelined_adder (WIDTH=32, STAGES=4): directed vector table,
// streaming, back-pressure, flush and reset sequences, then randomized
// traffic checked against an arithmetic reference model via a scoreboard.
module tb_pipelined_adder;

  localparam int unsigned W = 32;
  localparam int unsigned S = 4;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_ready, sub;
  logic         out_valid, out_ready, carry_out, overflow, zero;
  logic [W-1:0] a, b, sum;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         c;
    logic         ov;
    logic         z;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    res_t         exp;
  } vec_t;

  res_t exp_q[$];

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference: plain unsigned/signed arithmetic on the whole word.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s);
    res_t        r;
    longint      sx, sy, st;
    logic [W:0]  t;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      r.sum = x - y;
      r.c   = (x >= y);
      st    = sx - sy;
    end else begin
      t     = {1'b0, x} + {1'b0, y};
      r.sum = t[W-1:0];
      r.c   = t[W];
      st    = sx + sy;
    end
    r.ov = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    r.z  = (r.sum == '0);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: sampled on the falling edge, i.e. what the next rising edge does.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: out_valid=1 sum=%h with no pending op", sum);
        end else begin
          chk("sb_sum",   sum,             exp_q[0].sum);
          chk("sb_carry", 32'(carry_out),  32'(exp_q[0].c));
          chk("sb_ovf",   32'(overflow),   32'(exp_q[0].ov));
          chk("sb_zero",  32'(zero),       32'(exp_q[0].z));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(a, b, sub));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vec_t         vt[8];
    int           acc, nxt, got;
    logic [W-1:0] held, x;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sub = 1'b0; a = '0; b = '0;

    vt[0] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, '{32'h80000000, 1'b0, 1'b1, 1'b0}};
    vt[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
    vt[2] = '{32'h000000FF, 32'h00000001, 1'b0, '{32'h00000100, 1'b0, 1'b0, 1'b0}};
    vt[3] = '{32'h00000005, 32'h00000005, 1'b1, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
    vt[4] = '{32'h00000003, 32'h00000005, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0}};
    vt[5] = '{32'h80000000, 32'h00000001, 1'b1, '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}};
    vt[6] = '{32'h80000000, 32'h80000000, 1'b0, '{32'h00000000, 1'b1, 1'b1, 1'b1}};
    vt[7] = '{32'h0000FFFF, 32'h00010000, 1'b0, '{32'h0001FFFF, 1'b0, 1'b0, 1'b0}};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",       sum,            32'd0);
    chk("rst_carry",     32'(carry_out), 32'd0);
    chk("rst_ovf",       32'(overflow),  32'd0);
    chk("rst_zero",      32'(zero),      32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors, one at a time, with latency check
    for (int i = 0; i < 8; i++) begin
      a = vt[i].a; b = vt[i].b; sub = vt[i].sub;
      in_valid = 1'b1;
      chk("vec_in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      for (int k = 1; k < S; k++) begin
        chk("vec_early_valid", 32'(out_valid), 32'd0);
        step();
      end
      chk("vec_valid", 32'(out_valid),  32'd1);
      chk("vec_sum",   sum,             vt[i].exp.sum);
      chk("vec_carry", 32'(carry_out),  32'(vt[i].exp.c));
      chk("vec_ovf",   32'(overflow),   32'(vt[i].exp.ov));
      chk("vec_zero",  32'(zero),       32'(vt[i].exp.z));
      step();
    end

    // Streaming: 8 back-to-back adds, results in cycles 4..11
    for (int t = 0; t < 13; t++) begin
      if (t < 8) begin
        in_valid = 1'b1; sub = 1'b0;
        a = W'(t);
        b = W'(t) * 32'h10000001;
        chk("stream_in_ready", 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      chk("stream_valid", 32'(out_valid), 32'((t >= 4) && (t < 12)));
      if (t >= 4 && t < 12) begin
        x = W'(t - 4);
        chk("stream_sum", sum, x + x * 32'h10000001);
      end
      step();
    end

    // Back-pressure: out_ready low for 6 issue cycles
    out_ready = 1'b0; acc = 0; nxt = 0;
    for (int t = 0; t < 6; t++) begin
      in_valid = 1'b1;
      a = 32'h00001000 + W'(nxt);
      b = 32'h00000020 * W'(nxt + 1);
      sub = nxt[0];
      if (in_ready) begin
        acc++;
        nxt++;
      end
      step();
    end
    chk("bp_accepted", W'(acc), 32'd4);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    held = sum;
    repeat (2) step();
    chk("bp_sum_held", sum, held);
    chk("bp_in_ready_still_low", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1; got = 0;
    for (int t = 0; t < 12; t++) begin
      if (out_valid) got++;
      step();
    end
    chk("bp_drained", W'(got), 32'd4);

    // Flush: 3 ops in flight, then flush together with a new input
    for (int t = 0; t < 3; t++) begin
      in_valid = 1'b1; sub = 1'b0;
      a = 32'h00000100 * W'(t + 1); b = 32'h00000007;
      step();
    end
    flush = 1'b1; a = 32'hDEADBEEF; b = 32'h1;
    chk("flush_cycle_valid", 32'(out_valid), 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    for (int t = 0; t < 6; t++) begin
      chk("flush_no_valid", 32'(out_valid), 32'd0);
      step();
    end
    chk("flush_sb_empty", W'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-pipeline with a result held at the output
    out_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      in_valid = 1'b1; sub = 1'b0;
      a = 32'h00000011 * W'(t + 1); b = 32'h00000022;
      step();
    end
    in_valid = 1'b0;
    step();
    chk("rst_mid_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_sum",   sum,            32'd0);
    chk("rst_mid_carry", 32'(carry_out), 32'd0);
    chk("rst_mid_zero",  32'(zero),      32'd0);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      chk("rst_mid_no_valid", 32'(out_valid), 32'd0);
      step();
    end

    // Randomized traffic against the scoreboard
    for (int t = 0; t < 400; t++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      sub       = $urandom_range(0, 1) == 1;
      a = ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : $urandom();
      b = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom();
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) step();
    step();
    chk("drain_sb_empty", W'(exp_q.size()), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
